// File: rtl/clock_phase_gen.sv
// -----------------------------------------------------------------------------
// clock_phase_gen
//
// Multi-channel programmable clock-enable generator. Every channel owns a
// counter that wraps at its divide ratio. Each channel produces:
//   * a one-cycle enable pulse at a programmable phase.
//   * a 50%-duty level whose high half starts at that phase.
// All timing is derived from the single master clock, so no derived clocks are
// created.
//
// Configuration is written into per-channel shadow registers. A commit copies
// every shadow register into the active set during a single ALIGN cycle. That
// same cycle restarts all counters together, so the channels stay phase
// coherent.
//
// Ports
//   clock       master clock, all state on the rising edge
//   reset       asynchronous, active-low reset
//   run         1 = generate, 0 = return to IDLE
//   cfg_valid   shadow write request
//   cfg_ready   shadow write accepted when cfg_valid & cfg_ready (low in ALIGN)
//   cfg_ch      channel to write; out-of-range values handshake but are dropped
//   cfg_div     divide ratio (0 is stored as 1)
//   cfg_phase   phase offset (clamped to div-1)
//   cfg_commit  copy shadow -> active and realign all channels
//   ch_en       per-channel one-cycle enable pulse, once per period
//   ch_clk      per-channel registered 50%-duty level
//   epoch       pulse when every counter is 0 at the same time in RUN
//   busy        state != IDLE
// -----------------------------------------------------------------------------
module clock_phase_gen #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 8
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          run,
    input  logic                                          cfg_valid,
    output logic                                          cfg_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]                              cfg_div,
    input  logic [CNT_W-1:0]                              cfg_phase,
    input  logic                                          cfg_commit,
    output logic [NUM_CH-1:0]                             ch_en,
    output logic [NUM_CH-1:0]                             ch_clk,
    output logic                                          epoch,
    output logic                                          busy
);

    localparam int               CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ALIGN = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A commit wins over a falling run. ALIGN always lasts exactly one cycle
    // and ignores cfg_commit. Holding commit high therefore alternates
    // ALIGN with RUN/IDLE instead of locking the block in ALIGN.
    always_comb begin
        state_next = state_reg;
        cfg_ready  = 1'b1;
        busy       = 1'b1;
        case (state_reg)
            ST_IDLE: begin
                busy = 1'b0;
                if (cfg_commit) begin
                    state_next = ST_ALIGN;
                end else if (run) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cfg_commit) begin
                    state_next = ST_ALIGN;
                end else if (!run) begin
                    state_next = ST_IDLE;
                end
            end
            ST_ALIGN: begin
                cfg_ready  = 1'b0;
                state_next = run ? ST_RUN : ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shadow write data, normalised once for all channels
    // ------------------------------------------------------------------
    logic             shadow_wr;
    logic [CNT_W-1:0] div_in;
    logic [CNT_W-1:0] phase_in;

    always_comb begin
        shadow_wr = cfg_valid & cfg_ready;
        div_in    = (cfg_div == '0) ? ONE : cfg_div;
        // Clamp the phase so that the enable pulse can actually occur.
        phase_in  = (cfg_phase >= div_in) ? (div_in - ONE) : cfg_phase;
    end

    // ------------------------------------------------------------------
    // Per-channel datapath
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] cnt_zero;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] shadow_div_reg;
            logic [CNT_W-1:0] shadow_phase_reg;
            logic [CNT_W-1:0] div_reg;
            logic [CNT_W-1:0] phase_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic [CNT_W:0]   offset;
            logic [CNT_W:0]   half_div;
            logic             en_reg;
            logic             en_next;
            logic             clk_reg;
            logic             clk_next;

            always_comb begin
                // (cnt - phase) mod div. Both operands are below div, so one
                // conditional add of div replaces a real modulo. The extra bit
                // keeps cnt + div from overflowing.
                if (cnt_reg >= phase_reg) begin
                    offset = {1'b0, cnt_reg} - {1'b0, phase_reg};
                end else begin
                    offset = {1'b0, cnt_reg} + {1'b0, div_reg} - {1'b0, phase_reg};
                end
                // ceil(div/2): odd ratios get the extra cycle in the high half.
                half_div = ({1'b0, div_reg} + (CNT_W+1)'(1)) >> 1;
                cnt_next = (cnt_reg == div_reg - ONE) ? '0 : cnt_reg + ONE;
                en_next  = (cnt_reg == phase_reg);
                clk_next = (offset < half_div);
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    shadow_div_reg   <= DIV_RST;
                    shadow_phase_reg <= '0;
                    div_reg          <= DIV_RST;
                    phase_reg        <= '0;
                    cnt_reg          <= '0;
                    en_reg           <= 1'b0;
                    clk_reg          <= 1'b0;
                end else begin
                    // Out-of-range channel numbers match no instance and are
                    // dropped.
                    if (shadow_wr && (cfg_ch == CH_W'(gi))) begin
                        shadow_div_reg   <= div_in;
                        shadow_phase_reg <= phase_in;
                    end
                    case (state_reg)
                        ST_RUN: begin
                            cnt_reg <= cnt_next;
                            en_reg  <= en_next;
                            clk_reg <= clk_next;
                        end
                        ST_ALIGN: begin
                            // The shadow value seen here already includes a
                            // write accepted on the commit edge.
                            div_reg   <= shadow_div_reg;
                            phase_reg <= shadow_phase_reg;
                            cnt_reg   <= '0;
                            en_reg    <= 1'b0;
                            clk_reg   <= 1'b0;
                        end
                        default: begin
                            cnt_reg <= '0;
                            en_reg  <= 1'b0;
                            clk_reg <= 1'b0;
                        end
                    endcase
                end
            end

            assign ch_en[gi]    = en_reg;
            assign ch_clk[gi]   = clk_reg;
            assign cnt_zero[gi] = (cnt_reg == '0);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Epoch: all channels wrapped together
    // ------------------------------------------------------------------
    logic epoch_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            epoch_reg <= 1'b0;
        end else begin
            epoch_reg <= (state_reg == ST_RUN) && (&cnt_zero);
        end
    end

    assign epoch = epoch_reg;

endmodule

// File: tb/tb_clock_phase_gen.sv
// -----------------------------------------------------------------------------
// tb_clock_phase_gen
//
// Scoreboarded bench for clock_phase_gen.
//
// The stimulus process drives the inputs one clock at a time. After each
// edge it pushes the outputs it expects into a queue. The expected values come
// from hand-derived per-channel bit patterns, indexed by the cycle count since
// alignment. A separate monitor pops one entry on every falling edge and
// compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_clock_phase_gen;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    typedef enum int {M_IDLE, M_RUN, M_ALIGN} mstate_t;

    typedef struct packed {
        logic [NUM_CH-1:0] en;
        logic [NUM_CH-1:0] clk;
        logic              epoch;
        logic              busy;
        logic              ready;
    } exp_t;

    logic              clock      = 1'b0;
    logic              reset      = 1'b0;
    logic              run        = 1'b0;
    logic              cfg_valid  = 1'b0;
    logic              cfg_ready;
    logic [1:0]        cfg_ch     = '0;
    logic [CNT_W-1:0]  cfg_div    = '0;
    logic [CNT_W-1:0]  cfg_phase  = '0;
    logic              cfg_commit = 1'b0;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] ch_clk;
    logic              epoch;
    logic              busy;

    clock_phase_gen #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
        .cfg_phase  (cfg_phase),
        .cfg_commit (cfg_commit),
        .ch_en      (ch_en),
        .ch_clk     (ch_clk),
        .epoch      (epoch),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // Scoreboard
    exp_t  exp_q[$];
    string name_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    txn      = 0;

    // Expectation state. Patterns are indexed by counter value. Bit k of
    // en_pat/clk_pat is the output produced while the counter holds k.
    mstate_t     m_state = M_IDLE;
    int          age     = 0;
    int          act_period[NUM_CH];
    logic [15:0] act_en[NUM_CH];
    logic [15:0] act_clk[NUM_CH];
    int          act_ep;
    int          pend_period[NUM_CH];
    logic [15:0] pend_en[NUM_CH];
    logic [15:0] pend_clk[NUM_CH];
    int          pend_ep;

    // Default div 8, phase 0: pulse at cnt 0, high for cnt 0..3.
    task automatic model_reset();
        m_state = M_IDLE;
        age     = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            act_period[i]  = 8;
            act_en[i]      = 16'h0001;
            act_clk[i]     = 16'h000F;
            pend_period[i] = 8;
            pend_en[i]     = 16'h0001;
            pend_clk[i]    = 16'h000F;
        end
        act_ep  = 8;
        pend_ep = 8;
    endtask

    task automatic set_pending(input int ch, input int period,
                               input logic [15:0] en_pat, input logic [15:0] clk_pat);
        pend_period[ch] = period;
        pend_en[ch]     = en_pat;
        pend_clk[ch]    = clk_pat;
    endtask

    // One rising edge: derive what the outputs must be after it, then queue it.
    task automatic tick(input string name);
        exp_t    e;
        mstate_t ns;
        @(posedge clock);
        e = '0;
        if (!reset) begin
            model_reset();
            e.ready = 1'b1;
        end else begin
            if (m_state == M_RUN) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    e.en[i]  = act_en[i][age % act_period[i]];
                    e.clk[i] = act_clk[i][age % act_period[i]];
                end
                e.epoch = ((age % act_ep) == 0);
                age     = age + 1;
            end else begin
                age = 0;
            end
            if (m_state == M_ALIGN) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    act_period[i] = pend_period[i];
                    act_en[i]     = pend_en[i];
                    act_clk[i]    = pend_clk[i];
                end
                act_ep = pend_ep;
            end
            case (m_state)
                M_IDLE:  ns = cfg_commit ? M_ALIGN : (run ? M_RUN : M_IDLE);
                M_RUN:   ns = cfg_commit ? M_ALIGN : (run ? M_RUN : M_IDLE);
                default: ns = run ? M_RUN : M_IDLE;
            endcase
            e.busy  = (ns != M_IDLE);
            e.ready = (ns != M_ALIGN);
            m_state = ns;
        end
        #1;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic ticks(input int n, input string name);
        for (int k = 0; k < n; k++) begin
            tick(name);
        end
    endtask

    task automatic cfg_write(input int ch, input int div, input int ph,
                             input logic commit, input string name);
        cfg_valid  = 1'b1;
        cfg_ch     = 2'(ch);
        cfg_div    = 8'(div);
        cfg_phase  = 8'(ph);
        cfg_commit = commit;
        tick(name);
        cfg_valid  = 1'b0;
        cfg_commit = 1'b0;
    endtask

    function automatic void check(input string nm, input string field,
                                  input logic [NUM_CH-1:0] act, input logic [NUM_CH-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s %s: got %b expected %b", nm, field, act, req);
        end
    endfunction

    // Monitor: one transaction per falling edge whenever an expectation exists.
    initial begin : monitor
        exp_t  e;
        string nm;
        forever begin
            @(negedge clock);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                txn++;
                $display("txn %0d %s: ch_en=%b ch_clk=%b epoch=%b busy=%b cfg_ready=%b",
                         txn, nm, ch_en, ch_clk, epoch, busy, cfg_ready);
                check(nm, "ch_en", ch_en, e.en);
                check(nm, "ch_clk", ch_clk, e.clk);
                check(nm, "epoch", {3'b000, epoch}, {3'b000, e.epoch});
                check(nm, "busy", {3'b000, busy}, {3'b000, e.busy});
                check(nm, "cfg_ready", {3'b000, cfg_ready}, {3'b000, e.ready});
            end
        end
    end

    initial begin : stimulus
        exp_t e;
        model_reset();

        // Reset held, then idle with run low.
        ticks(2, "reset");
        reset = 1'b1;
        ticks(2, "idle");

        // Defaults: every channel div 8, phase 0; epoch every 8.
        run = 1'b1;
        ticks(20, "default");

        // Shadow writes in RUN; outputs keep the default pattern until commit.
        // ch0 div3 ph0, ch1 div5 ph2, ch2 div3 ph1, ch3 div5 ph0 -> epoch 15.
        set_pending(0, 3, 16'h0001, 16'h0003);
        cfg_write(0, 3, 0, 1'b0, "wr_ch0");
        set_pending(1, 5, 16'h0004, 16'h001C);
        cfg_write(1, 5, 2, 1'b0, "wr_ch1");
        set_pending(2, 3, 16'h0002, 16'h0006);
        cfg_write(2, 3, 1, 1'b0, "wr_ch2");
        set_pending(3, 5, 16'h0001, 16'h0007);
        cfg_write(3, 5, 0, 1'b0, "wr_ch3");
        pend_ep = 15;
        ticks(3, "shadow_only");
        cfg_commit = 1'b1;
        tick("commit_a");
        cfg_commit = 1'b0;
        ticks(35, "div3_5");

        // div 0 / phase 9 on ch2, written on the same edge as the commit.
        // It must behave as div 1, with ch_en and ch_clk steady high.
        set_pending(2, 1, 16'h0001, 16'h0001);
        cfg_write(2, 0, 9, 1'b1, "wr_commit_ch2");
        ticks(12, "div1");

        // ch0 div4 phase 6 (clamped to 3) without commit: no visible change.
        set_pending(0, 4, 16'h0008, 16'h0009);
        pend_ep = 20;
        cfg_write(0, 4, 6, 1'b0, "wr_ch0_div4");
        ticks(6, "nocommit");
        cfg_commit = 1'b1;
        tick("commit_b");
        cfg_commit = 1'b0;
        ticks(25, "div4");

        // Commit held high: ALIGN alternates with RUN.
        cfg_commit = 1'b1;
        ticks(4, "commit_hold");
        cfg_commit = 1'b0;
        ticks(5, "after_hold");

        // Run dropped mid-period, then restarted from cnt 0.
        run = 1'b0;
        ticks(3, "stop");
        run = 1'b1;
        ticks(10, "restart");

        // Asynchronous reset between edges: outputs clear before the next edge.
        @(posedge clock);
        #2;
        reset = 1'b0;
        model_reset();
        e       = '0;
        e.ready = 1'b1;
        exp_q.push_back(e);
        name_q.push_back("reset_async");
        tick("reset_hold");
        reset = 1'b1;
        ticks(12, "post_reset");

        // Let the monitor drain the last entry.
        @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
